vend_change_dispenser: RTL and testbench
========================================

Name: vend_change_dispenser

Overview:
- Pays out change from the vending machine's remaining balance, the other end of the coin path: the vending core accepts 5/10/20 coins, and this block ejects coins.
- Takes a change amount with a one-cycle request and drives timed eject pulses to the 10-coin and 5-coin ejector solenoids, largest coin first.
- Tracks the on-board 5 and 10 coin inventory and flags a shortfall when exact change cannot be paid.

Parameters:
- HOLD_CYCLES, 4, eject pulse width in clocks (>=1)
- GAP_CYCLES, 2, idle clocks after each eject pulse before the next decision (>=1)
- INV_W, 8, width of the inventory counters

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- ena  input  1  clock enable; 0 freezes all state and outputs
- req  input  1  start payout; sampled only in IDLE
- amount  input  7  change value in currency units (0..127), latched on accepted req
- inv_load  input  1  load inventory counters; honoured only in IDLE
- inv5_in  input  INV_W  5-coin count loaded on inv_load
- inv10_in  input  INV_W  10-coin count loaded on inv_load
- eject5  output  1  5-coin solenoid drive
- eject10  output  1  10-coin solenoid drive
- busy  output  1  high in every state except IDLE
- done  output  1  one-cycle pulse when a payout finishes
- short  output  1  payout finished with nonzero remainder; held until next accepted req
- remaining  output  7  unpaid amount
- inv5_cnt  output  INV_W  current 5-coin inventory
- inv10_cnt  output  INV_W  current 10-coin inventory

Behaviour:
- All outputs reset to 0, state resets to IDLE, and the FSM returns to IDLE immediately on a mid-payout reset. Inventory also resets to 0 and must be reloaded.
- All transitions occur only when ena=1. With ena=0 the state, counters and outputs hold, including an eject pulse in progress.
- Only the rising edge of clk advances state.
- States are IDLE, CHECK, PULSE, GAP and DONE.
- IDLE:
  - req=1 latches amount into remaining, clears short and goes to CHECK.
  - inv_load=1 with req=0 loads both counters.
  - inv_load=1 with req=1 in the same cycle loads the counters first, then the payout starts from CHECK using the new counts.
- CHECK (one cycle) picks the first matching case:
  - remaining>=10 and inv10_cnt>0: select coin 10.
  - else remaining>=5 and inv5_cnt>0: select coin 5.
  - else go to DONE.
- When a coin is selected:
  - On the CHECK→PULSE edge, remaining decreases by the coin value and the matching counter decrements.
  - The matching eject output is registered high for exactly HOLD_CYCLES clocks in PULSE.
  - The FSM then spends GAP_CYCLES in GAP with both ejects low, then returns to CHECK.
- eject5 and eject10 are never high together.
- DONE (one cycle): done=1, short=(remaining!=0), then IDLE. remaining holds its final value until the next accepted req.
- req and inv_load while busy are ignored, with no queuing.
- A remainder of 1..4 is unpayable and ends with short=1.
- amount=0 goes CHECK→DONE with done=1, short=0 and no ejects.
- Counters never underflow because selection requires a count >0.
- Latency: req accepted at edge N → CHECK at N+1 → eject high from N+2.
- Each coin costs 1+HOLD_CYCLES+GAP_CYCLES clocks. The final CHECK+DONE costs 2 clocks.

Test Plan:
- Reset, then load inv5=3, inv10=2, then req with amount=15 → eject10 high for 4 clocks starting 2 clocks after req, 2-clock gap, then eject5 for 4 clocks. Then done pulse with short=0, remaining=0, inv5_cnt=2, inv10_cnt=1. Total 16 clocks from req to done.
- Load inv5=4, inv10=0, then req with amount=20 → four eject5 pulses, eject10 never high, remaining=0, inv5_cnt=0, short=0.
- Load inv5=1, inv10=1, then req with amount=25 → one eject10 and one eject5 pulse, then done with short=1, remaining=10, inventory both 0.
- req with amount=7 (stock ample) → one eject5 pulse, done, short=1, remaining=2. Also req with amount=0 → done two clocks after req with no eject.
- Mid-payout: assert req while busy and inv_load while busy → both ignored and counts unchanged. Hold ena=0 for 5 clocks during eject10 → pulse stretches by exactly 5 clocks.
- Assert rst_n=0 asynchronously during a PULSE → eject outputs drop immediately without waiting for clk, and all outputs read 0. After release, req with no inventory loaded → done with short=1.

Source files
------------

// File: rtl/vend_change_dispenser.sv
// vend_change_dispenser
// Pays out change from the balance handed over by the vending core. A one-cycle
// req latches 'amount'. The FSM then ejects 10-coins while the balance allows
// and stock lasts, then 5-coins, one timed solenoid pulse at a time. It stops
// when no further coin fits or stock runs out, and flags 'short' if any balance
// is left unpaid.
//
// Handshake: req and inv_load are sampled only in IDLE while ena=1. In any
// other state they are dropped, with no queuing. done is a one-cycle pulse that
// marks completion. short and remaining stay valid until the next accepted req.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   ena                 clock enable; 0 freezes every register
//   req, amount[6:0]    payout request and value (0..127)
//   inv_load            loads inv5_in/inv10_in into the coin counters (IDLE only)
//   eject5, eject10     solenoid drives, never high together
//   busy                high outside IDLE
//   done                one-cycle completion pulse
//   short               last payout left a nonzero remainder
//   remaining[6:0]      unpaid balance
//   inv5_cnt, inv10_cnt current coin stock
//   state_dbg[2:0]      current FSM state, for checkers
module vend_change_dispenser #(
  parameter int HOLD_CYCLES = 4,
  parameter int GAP_CYCLES  = 2,
  parameter int INV_W       = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic             req,
  input  logic [6:0]       amount,
  input  logic             inv_load,
  input  logic [INV_W-1:0] inv5_in,
  input  logic [INV_W-1:0] inv10_in,
  output logic             eject5,
  output logic             eject10,
  output logic             busy,
  output logic             done,
  output logic             short,
  output logic [6:0]       remaining,
  output logic [INV_W-1:0] inv5_cnt,
  output logic [INV_W-1:0] inv10_cnt,
  output logic [2:0]       state_dbg
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CHECK = 3'd1;
  localparam logic [2:0] S_PULSE = 3'd2;
  localparam logic [2:0] S_GAP   = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  // One down-counter serves both the pulse and the gap phase.
  localparam int MAX_CNT = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int CNT_W   = (MAX_CNT > 1) ? $clog2(MAX_CNT) : 1;

  logic [2:0]       state;
  logic [CNT_W-1:0] cnt;

  assign busy      = (state != S_IDLE);
  assign state_dbg = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      cnt       <= '0;
      eject5    <= 1'b0;
      eject10   <= 1'b0;
      done      <= 1'b0;
      short     <= 1'b0;
      remaining <= '0;
      inv5_cnt  <= '0;
      inv10_cnt <= '0;
    end else if (ena) begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          // A load in the same cycle as req lands first, so CHECK sees the new stock.
          if (inv_load) begin
            inv5_cnt  <= inv5_in;
            inv10_cnt <= inv10_in;
          end
          if (req) begin
            remaining <= amount;
            short     <= 1'b0;
            state     <= S_CHECK;
          end
        end
        S_CHECK: begin
          // Largest coin first. A nonzero count is required, so the counters cannot underflow.
          if (remaining >= 7'd10 && inv10_cnt != '0) begin
            remaining <= remaining - 7'd10;
            inv10_cnt <= inv10_cnt - INV_W'(1);
            eject10   <= 1'b1;
            cnt       <= CNT_W'(HOLD_CYCLES - 1);
            state     <= S_PULSE;
          end else if (remaining >= 7'd5 && inv5_cnt != '0) begin
            remaining <= remaining - 7'd5;
            inv5_cnt  <= inv5_cnt - INV_W'(1);
            eject5    <= 1'b1;
            cnt       <= CNT_W'(HOLD_CYCLES - 1);
            state     <= S_PULSE;
          end else begin
            done  <= 1'b1;
            short <= (remaining != 7'd0);
            state <= S_DONE;
          end
        end
        S_PULSE: begin
          if (cnt == '0) begin
            eject5  <= 1'b0;
            eject10 <= 1'b0;
            cnt     <= CNT_W'(GAP_CYCLES - 1);
            state   <= S_GAP;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        S_GAP: begin
          if (cnt == '0) begin
            state <= S_CHECK;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state   <= S_IDLE;
          eject5  <= 1'b0;
          eject10 <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vend_change_dispenser.sv
// Testbench for vend_change_dispenser. Inputs are driven on the falling edge,
// and outputs are sampled on the same falling edge before new values are driven.
// For each payout, the expected cycle-by-cycle {done, eject10, eject5} waveform
// is built from a coin list worked out arithmetically: greedy 10s limited by
// stock, then 5s limited by stock. That waveform is queued in exp_q.
module tb_vend_change_dispenser;

  localparam int HOLD  = 4;
  localparam int GAP   = 2;
  localparam int INV_W = 8;

  logic             clk;
  logic             rst_n;
  logic             ena;
  logic             req;
  logic [6:0]       amount;
  logic             inv_load;
  logic [INV_W-1:0] inv5_in;
  logic [INV_W-1:0] inv10_in;
  logic             eject5;
  logic             eject10;
  logic             busy;
  logic             done;
  logic             short;
  logic [6:0]       remaining;
  logic [INV_W-1:0] inv5_cnt;
  logic [INV_W-1:0] inv10_cnt;
  logic [2:0]       state_dbg;

  int compared;
  int mismatched;
  int m_inv5;
  int m_inv10;

  logic [2:0] exp_q[$];

  vend_change_dispenser #(
    .HOLD_CYCLES(HOLD),
    .GAP_CYCLES (GAP),
    .INV_W      (INV_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ena       (ena),
    .req       (req),
    .amount    (amount),
    .inv_load  (inv_load),
    .inv5_in   (inv5_in),
    .inv10_in  (inv10_in),
    .eject5    (eject5),
    .eject10   (eject10),
    .busy      (busy),
    .done      (done),
    .short     (short),
    .remaining (remaining),
    .inv5_cnt  (inv5_cnt),
    .inv10_cnt (inv10_cnt),
    .state_dbg (state_dbg)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Issue one payout and check it cycle by cycle against the coin-list model.
  // Sample k is taken on the falling edge after the k-th rising edge following
  // acceptance of the request.
  task automatic run_payout(input string name, input int amt, input bit do_load,
                            input int l5, input int l10, input bit disturb);
    int n10, n5, rem, k;
    logic [2:0] obs, expv;
    @(negedge clk);
    if (do_load) begin
      inv_load = 1'b1;
      inv5_in  = INV_W'(l5);
      inv10_in = INV_W'(l10);
      m_inv5   = l5;
      m_inv10  = l10;
    end
    req    = 1'b1;
    amount = 7'(amt);
    rem = amt;
    n10 = rem / 10;
    if (n10 > m_inv10) n10 = m_inv10;
    rem = rem - 10 * n10;
    n5 = rem / 5;
    if (n5 > m_inv5) n5 = m_inv5;
    rem = rem - 5 * n5;
    m_inv10 = m_inv10 - n10;
    m_inv5  = m_inv5 - n5;
    exp_q.delete();
    repeat (n10) begin
      exp_q.push_back(3'b000);
      repeat (HOLD) exp_q.push_back(3'b010);
      repeat (GAP) exp_q.push_back(3'b000);
    end
    repeat (n5) begin
      exp_q.push_back(3'b000);
      repeat (HOLD) exp_q.push_back(3'b001);
      repeat (GAP) exp_q.push_back(3'b000);
    end
    exp_q.push_back(3'b000);
    exp_q.push_back(3'b100);
    k = 0;
    while (exp_q.size() > 0) begin
      @(negedge clk);
      obs  = {done, eject10, eject5};
      expv = exp_q.pop_front();
      compared++;
      if (obs !== expv) begin
        mismatched++;
        $display("FAIL %s wave k=%0d: got {done,e10,e5}=%b expected %b", name, k, obs, expv);
      end
      if (k == 0) begin
        req      = 1'b0;
        inv_load = 1'b0;
      end
      if (disturb && k == 3) begin
        req      = 1'b1;
        amount   = 7'($urandom_range(0, 127));
        inv_load = 1'b1;
        inv5_in  = INV_W'($urandom_range(0, 3));
        inv10_in = INV_W'($urandom_range(0, 3));
      end
      if (disturb && k == 4) begin
        req      = 1'b0;
        inv_load = 1'b0;
      end
      k++;
    end
    // The last sample is the DONE cycle.
    compared++;
    if (short !== (rem != 0)) begin
      mismatched++;
      $display("FAIL %s short: got %b expected %b", name, short, (rem != 0));
    end
    compared++;
    if (remaining !== 7'(rem)) begin
      mismatched++;
      $display("FAIL %s remaining: got %0d expected %0d", name, remaining, rem);
    end
    compared++;
    if (inv5_cnt !== INV_W'(m_inv5) || inv10_cnt !== INV_W'(m_inv10)) begin
      mismatched++;
      $display("FAIL %s inventory: got %0d/%0d expected %0d/%0d", name,
               inv5_cnt, inv10_cnt, m_inv5, m_inv10);
    end
    req      = 1'b0;
    inv_load = 1'b0;
    @(negedge clk);
    compared++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      mismatched++;
      $display("FAIL %s idle after done: got busy=%b done=%b expected 0 0", name, busy, done);
    end
  endtask

  task automatic check_all_zero(input string name);
    compared++;
    if ({eject5, eject10, busy, done, short} !== 5'b0 || remaining !== 7'd0 ||
        inv5_cnt !== '0 || inv10_cnt !== '0) begin
      mismatched++;
      $display("FAIL %s: got e5=%b e10=%b busy=%b done=%b short=%b rem=%0d inv=%0d/%0d expected all 0",
               name, eject5, eject10, busy, done, short, remaining, inv5_cnt, inv10_cnt);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; ena = 1'b1; req = 1'b0; amount = '0;
    inv_load = 1'b0; inv5_in = '0; inv10_in = '0;
    m_inv5 = 0; m_inv10 = 0;
    #12;
    check_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    run_payout("basic15", 15, 1'b1, 3, 2, 1'b0);
  endtask

  task automatic test_only_fives();
    run_payout("only5", 20, 1'b1, 4, 0, 1'b0);
  endtask

  task automatic test_stock_short();
    run_payout("stock_short", 25, 1'b1, 1, 1, 1'b0);
  endtask

  task automatic test_remainder_and_zero();
    run_payout("amt7", 7, 1'b1, 10, 10, 1'b0);
    run_payout("amt0", 0, 1'b0, 0, 0, 1'b0);
  endtask

  task automatic test_busy_ignored();
    run_payout("busy_ignore", 35, 1'b1, 6, 2, 1'b1);
  endtask

  // Hold ena low for 5 clocks inside a 10-coin pulse: the pulse and the whole
  // payout stretch by exactly 5 clocks.
  task automatic test_ena_freeze();
    int highs, done_k;
    @(negedge clk);
    inv_load = 1'b1; inv5_in = '0; inv10_in = INV_W'(5);
    @(negedge clk);
    inv_load = 1'b0; req = 1'b1; amount = 7'd10;
    m_inv5 = 0; m_inv10 = 4;
    highs = 0; done_k = -1;
    for (int k = 0; k < 40 && done_k < 0; k++) begin
      @(negedge clk);
      if (k == 0) req = 1'b0;
      if (eject10 === 1'b1) highs++;
      if (done === 1'b1) done_k = k;
      if (k == 2) ena = 1'b0;
      if (k == 7) ena = 1'b1;
    end
    ena = 1'b1;
    compared++;
    if (highs != HOLD + 5) begin
      mismatched++;
      $display("FAIL ena_freeze pulse: got %0d high clocks expected %0d", highs, HOLD + 5);
    end
    compared++;
    if (done_k != 1 + HOLD + GAP + 1 + 5) begin
      mismatched++;
      $display("FAIL ena_freeze done time: got k=%0d expected %0d", done_k, 1 + HOLD + GAP + 1 + 5);
    end
    compared++;
    if (inv10_cnt !== INV_W'(m_inv10)) begin
      mismatched++;
      $display("FAIL ena_freeze inv10: got %0d expected %0d", inv10_cnt, m_inv10);
    end
    @(negedge clk);
  endtask

  // Reset is asserted between clock edges during a pulse.
  task automatic test_async_reset();
    @(negedge clk);
    inv_load = 1'b1; inv5_in = INV_W'(5); inv10_in = INV_W'(5);
    req = 1'b1; amount = 7'd20;
    @(negedge clk);
    inv_load = 1'b0; req = 1'b0;
    @(negedge clk);
    compared++;
    if (eject10 !== 1'b1) begin
      mismatched++;
      $display("FAIL async_reset setup: got eject10=%b expected 1", eject10);
    end
    #2 rst_n = 1'b0;
    #1 check_all_zero("async_reset");
    #1 rst_n = 1'b1;
    m_inv5 = 0; m_inv10 = 0;
    run_payout("no_stock", 15, 1'b0, 0, 0, 1'b0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 20; i++) begin
      run_payout("random", int'($urandom_range(0, 127)), ($urandom_range(0, 2) != 0),
                 int'($urandom_range(0, 12)), int'($urandom_range(0, 8)),
                 bit'($urandom_range(0, 1)));
    end
  endtask

  initial begin
    compared = 0;
    mismatched = 0;
    test_reset();
    test_basic();
    test_only_fives();
    test_stock_short();
    test_remainder_and_zero();
    test_busy_ignored();
    test_ena_freeze();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  // Independent guard: the two solenoids must never be driven together.
  always @(negedge clk) begin
    if (eject5 === 1'b1 && eject10 === 1'b1) begin
      compared++;
      mismatched++;
      $display("FAIL both_ejects: got e5=1 e10=1 expected at most one high");
    end
  end

endmodule
